// File: rtl/cam_capture_seq_if.sv
// cam_capture_seq_if: dither BRAM read, pixel stream and frame RAM write ports of the capture sequencer.
interface cam_capture_seq_if;
  logic [9:0]  Dth_Addr;
  logic [7:0]  Dth_Data;
  logic        Pix_Start;
  logic        Pix_Valid;
  logic [7:0]  Pix_Data;
  logic        Pix_Ready;
  logic        Frm_We;
  logic [12:0] Frm_Addr;
  logic [7:0]  Frm_Data;
  modport master (
    output Dth_Addr, Pix_Start, Pix_Ready, Frm_We, Frm_Addr, Frm_Data,
    input  Dth_Data, Pix_Valid, Pix_Data
  );
  modport slave (
    input  Dth_Addr, Pix_Start, Pix_Ready, Frm_We, Frm_Addr, Frm_Data,
    output Dth_Data, Pix_Valid, Pix_Data
  );
endinterface

// File: rtl/cam_capture_seq.sv
// cam_capture_seq: loads dither thresholds, waits out exposure, then dithers a 128x112 stream into 2bpp tiles.
module cam_capture_seq (
  input  logic             sys_clock,
  input  logic             sys_resetn,
  input  logic             Cam_Capture,
  input  logic [7:0]       Reg_A002,
  input  logic [7:0]       Reg_A003,
  input  logic             Tick_16us,
  output logic             Sig_CamCaptureFinish,
  cam_capture_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, EXPOSE, STREAM, WR_LO, WR_HI, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d;
  logic        last_q, last_d;
  logic [7:0]  thr_q [48];
  logic [7:0]  thr_d [48];
  logic [9:0]  dth_addr_q, dth_addr_d;
  logic        pix_start_q, pix_start_d, pix_ready_q, pix_ready_d;
  logic        frm_we_q, frm_we_d, finish_q, finish_d;
  logic [12:0] frm_addr_q, frm_addr_d;
  logic [7:0]  frm_data_q, frm_data_d;
  logic        cap, rise, accept;
  logic [5:0]  idx;
  logic [1:0]  n_ge, colour;
  assign cap    = sync_q[1];
  assign rise   = sync_q[1] & ~sync_q[2];
  assign accept = pix_ready_q & bus.Pix_Valid;
  assign idx    = {2'b00, y_q[1:0], x_q[1:0]} * 6'd3;
  assign n_ge   = {1'b0, bus.Pix_Data >= thr_q[idx]} + {1'b0, bus.Pix_Data >= thr_q[idx + 6'd1]}
                + {1'b0, bus.Pix_Data >= thr_q[idx + 6'd2]};
  assign colour = 2'd3 - n_ge;
  always_comb begin
    sync_d     = {sync_q[1:0], Cam_Capture};
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    x_d        = x_q;
    y_d        = y_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    last_d     = last_q;
    thr_d      = thr_q;
    frm_addr_d = '0;
    frm_data_d = '0;
    case (state_q)
      IDLE: begin
        x_d    = '0;
        y_d    = '0;
        last_d = 1'b0;
        cnt_d  = '0;
        if (rise) state_d = LOAD;
      end
      LOAD: begin
        // BRAM data lags its address by one cycle, so entry i lands while cnt is i+1
        if (cnt_q != 6'd0) thr_d[cnt_q - 6'd1] = bus.Dth_Data;
        cnt_d = cnt_q + 6'd1;
        if (!cap) state_d = IDLE;
        else if (cnt_q == 6'd48) begin
          exp_d   = {Reg_A002, Reg_A003};
          state_d = (exp_d == 16'd0) ? STREAM : EXPOSE;
        end
      end
      EXPOSE: begin
        if (!cap) state_d = IDLE;
        else if (exp_q == 16'd0) state_d = STREAM;
        else if (Tick_16us) exp_d = exp_q - 16'd1;
      end
      STREAM: begin
        if (!cap) state_d = IDLE;
        else if (accept) begin
          lo_d = {colour[0], lo_q[7:1]};
          hi_d = {colour[1], hi_q[7:1]};
          x_d  = x_q + 7'd1;
          if (x_q == 7'd127) y_d = y_q + 7'd1;
          if (x_q[2:0] == 3'd7) begin
            state_d    = WR_LO;
            frm_addr_d = 13'h100 + {1'b0, y_q[6:3], x_q[6:3], y_q[2:0], 1'b0};
            frm_data_d = lo_d;
            last_d     = (x_q == 7'd127) && (y_q == 7'd111);
          end
        end
      end
      WR_LO: begin
        state_d    = WR_HI;
        frm_addr_d = frm_addr_q + 13'd1;
        frm_data_d = hi_q;
      end
      WR_HI: begin
        cnt_d   = '0;
        state_d = !cap ? IDLE : last_q ? DONE : STREAM;
      end
      DONE: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pix_start_d = (state_d == STREAM) && (state_q == LOAD || state_q == EXPOSE);
    pix_ready_d = state_d == STREAM;
    frm_we_d    = (state_d == WR_LO) || (state_d == WR_HI);
    finish_d    = state_d == DONE;
    dth_addr_d  = (state_d == LOAD && cnt_d < 6'd48) ? {4'b1000, cnt_d} : 10'd0;
  end
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      last_q      <= 1'b0;
      thr_q       <= '{default: '0};
      dth_addr_q  <= '0;
      pix_start_q <= 1'b0;
      pix_ready_q <= 1'b0;
      frm_we_q    <= 1'b0;
      frm_addr_q  <= '0;
      frm_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      x_q         <= x_d;
      y_q         <= y_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      last_q      <= last_d;
      thr_q       <= thr_d;
      dth_addr_q  <= dth_addr_d;
      pix_start_q <= pix_start_d;
      pix_ready_q <= pix_ready_d;
      frm_we_q    <= frm_we_d;
      frm_addr_q  <= frm_addr_d;
      frm_data_q  <= frm_data_d;
      finish_q    <= finish_d;
    end
  end
  assign bus.Dth_Addr          = dth_addr_q;
  assign bus.Pix_Start         = pix_start_q;
  assign bus.Pix_Ready         = pix_ready_q;
  assign bus.Frm_We            = frm_we_q;
  assign bus.Frm_Addr          = frm_addr_q;
  assign bus.Frm_Data          = frm_data_q;
  assign Sig_CamCaptureFinish  = finish_q;
endmodule

// File: tb/tb_cam_capture_seq.sv
// tb_cam_capture_seq: directed scenarios for the capture sequencer with a BRAM model and a pixel source.
module tb_cam_capture_seq;
  logic       sys_clock = 1'b0;
  logic       sys_resetn = 1'b0;
  logic       Cam_Capture = 1'b0;
  logic       Tick_16us = 1'b0;
  logic [7:0] Reg_A002 = 8'h00;
  logic [7:0] Reg_A003 = 8'h00;
  logic       Sig_CamCaptureFinish;
  cam_capture_seq_if bus();
  cam_capture_seq dut (
    .sys_clock(sys_clock),
    .sys_resetn(sys_resetn),
    .Cam_Capture(Cam_Capture),
    .Reg_A002(Reg_A002),
    .Reg_A003(Reg_A003),
    .Tick_16us(Tick_16us),
    .Sig_CamCaptureFinish(Sig_CamCaptureFinish),
    .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  logic [7:0] bram [1024];
  int pix_idx = 0;
  int cyc = 0;
  logic pix_mode = 1'b0;
  logic gap_en = 1'b0;
  logic valid_en = 1'b0;
  always #5 sys_clock = ~sys_clock;
  always @(posedge sys_clock) begin
    bus.Dth_Data <= bram[bus.Dth_Addr];
    cyc <= cyc + 1;
    if (bus.Pix_Start) pix_idx <= (bus.Pix_Valid && bus.Pix_Ready) ? 1 : 0;
    else if (bus.Pix_Valid && bus.Pix_Ready) pix_idx <= pix_idx + 1;
  end
  assign bus.Pix_Valid = valid_en && !(gap_en && (cyc % 5 == 3));
  assign bus.Pix_Data  = !pix_mode ? 8'hFF :
                         (pix_idx % 4 == 0) ? 8'h00 :
                         (pix_idx % 4 == 1) ? 8'h50 :
                         (pix_idx % 4 == 2) ? 8'h90 : 8'hD0;
  function automatic logic [34:0] outs();
    return {Sig_CamCaptureFinish, bus.Pix_Start, bus.Pix_Ready, bus.Frm_We,
            bus.Frm_Addr, bus.Frm_Data, bus.Dth_Addr};
  endfunction
  function automatic logic [12:0] wr_addr(input int n);
    int p, y;
    p = n / 2;
    y = p / 16;
    return 13'(256 + ((y / 8) * 16 + p % 16) * 16 + (y % 8) * 2 + n % 2);
  endfunction
  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge sys_clock);
      if (bus.Dth_Addr == 10'h200) ok = 1'b1;
    end
  endtask
  task automatic fill_flat(input logic [7:0] v);
    for (int i = 0; i < 48; i++) bram[10'h200 + i] = v;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge sys_clock);
    checks++;
    if (outs() !== 35'd0) begin errors++; $display("FAIL reset_outs: got %0h expected 0", outs()); end
    Cam_Capture = 1'b1;
    repeat (6) @(negedge sys_clock);
    checks++;
    if (outs() !== 35'd0) begin errors++; $display("FAIL reset_hold_idle: got %0h expected 0", outs()); end
    Cam_Capture = 1'b0;
    sys_resetn = 1'b1;
    repeat (5) @(negedge sys_clock);
    checks++;
    if (outs() !== 35'd0) begin errors++; $display("FAIL post_reset_idle: got %0h expected 0", outs()); end
  endtask
  task automatic test_full_frame;
    bit ok, done;
    int bad, n, bad_addr, bad_data, fin;
    logic [12:0] last_addr;
    fill_flat(8'h80);
    {Reg_A002, Reg_A003} = 16'h0000;
    pix_mode = 1'b0; gap_en = 1'b0; valid_en = 1'b1;
    Cam_Capture = 1'b1;
    wait_load(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ff_load_start: got none expected Dth_Addr 200"); end
    bad = 0;
    for (int i = 1; i < 48; i++) begin
      @(negedge sys_clock);
      if (bus.Dth_Addr !== 10'(10'h200 + i)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ff_load_addr: got %0d bad expected 0", bad); end
    repeat (2) @(negedge sys_clock);
    checks++;
    if (bus.Pix_Start !== 1'b1) begin errors++; $display("FAIL ff_load_len: got Pix_Start %b at cycle 49 expected 1", bus.Pix_Start); end
    n = 0; bad_addr = 0; bad_data = 0; fin = 0; done = 1'b0; last_addr = '0;
    for (int c = 0; c < 25000 && !done; c++) begin
      @(negedge sys_clock);
      if (bus.Frm_We) begin
        if (bus.Frm_Addr !== wr_addr(n)) bad_addr++;
        if (bus.Frm_Data !== 8'h00) bad_data++;
        last_addr = bus.Frm_Addr;
        n++;
      end
      if (Sig_CamCaptureFinish) fin++;
      else if (fin > 0) done = 1'b1;
    end
    checks++;
    if (n != 3584) begin errors++; $display("FAIL ff_write_count: got %0d expected 3584", n); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL ff_write_addr: got %0d bad expected 0", bad_addr); end
    checks++;
    if (bad_data != 0) begin errors++; $display("FAIL ff_write_data: got %0d bad expected 0", bad_data); end
    checks++;
    if (last_addr !== 13'h0EFF) begin errors++; $display("FAIL ff_last_addr: got %0h expected eff", last_addr); end
    checks++;
    if (fin != 8 || !done) begin errors++; $display("FAIL ff_finish_len: got %0d done %b expected 8", fin, done); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clock);
      if (bus.Dth_Addr != 10'd0 || bus.Pix_Start || bus.Frm_We) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ff_no_retrigger: got %0d active cycles expected 0", bad); end
    Cam_Capture = 1'b0;
    repeat (5) @(negedge sys_clock);
  endtask
  task automatic test_exposure;
    bit ok;
    int ticks, last_tick, start_c;
    fill_flat(8'h80);
    {Reg_A002, Reg_A003} = 16'h0003;
    pix_mode = 1'b0; gap_en = 1'b0; valid_en = 1'b1;
    Cam_Capture = 1'b1;
    wait_load(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL exp_load_start: got none expected Dth_Addr 200"); end
    repeat (48) @(negedge sys_clock);
    ticks = 0; last_tick = -100; start_c = -1;
    for (int c = 0; c < 100 && start_c < 0; c++) begin
      @(negedge sys_clock);
      if (bus.Pix_Start) start_c = c;
      else begin
        Tick_16us = (c % 10 == 5);
        if (Tick_16us) begin ticks++; last_tick = c; end
        if (c == 1) {Reg_A002, Reg_A003} = 16'hFFFF;
      end
    end
    Tick_16us = 1'b0;
    checks++;
    if (ticks != 3) begin errors++; $display("FAIL exp_ticks: got %0d expected 3", ticks); end
    checks++;
    if (start_c - last_tick != 2) begin errors++; $display("FAIL exp_start_delay: got %0d expected 2", start_c - last_tick); end
    @(negedge sys_clock);
    checks++;
    if ({bus.Pix_Start, bus.Pix_Ready} !== 2'b01) begin errors++; $display("FAIL exp_start_pulse: got %b expected 01", {bus.Pix_Start, bus.Pix_Ready}); end
    Cam_Capture = 1'b0;
    {Reg_A002, Reg_A003} = 16'h0000;
    repeat (10) @(negedge sys_clock);
    checks++;
    if (bus.Pix_Ready !== 1'b0) begin errors++; $display("FAIL exp_abort_ready: got %b expected 0", bus.Pix_Ready); end
  endtask
  task automatic test_pattern_abort;
    bit ok;
    int n, post, fin;
    logic [20:0] w [4];
    for (int k = 0; k < 16; k++) begin
      bram[10'h200 + 3 * k]     = 8'h40;
      bram[10'h200 + 3 * k + 1] = 8'h80;
      bram[10'h200 + 3 * k + 2] = 8'hC0;
    end
    {Reg_A002, Reg_A003} = 16'h0000;
    pix_mode = 1'b1; gap_en = 1'b1; valid_en = 1'b1;
    for (int i = 0; i < 4; i++) w[i] = '0;
    Cam_Capture = 1'b1;
    wait_load(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pat_load_start: got none expected Dth_Addr 200"); end
    n = 0;
    for (int c = 0; c < 8000 && n < 340; c++) begin
      @(negedge sys_clock);
      if (bus.Frm_We) begin
        if (n < 2) w[n] = {bus.Frm_Addr, bus.Frm_Data};
        if (n == 290 || n == 291) w[n - 288] = {bus.Frm_Addr, bus.Frm_Data};
        n++;
      end
    end
    Cam_Capture = 1'b0;
    checks++;
    if (n != 340) begin errors++; $display("FAIL pat_write_count: got %0d expected 340", n); end
    checks++;
    if (w[0] !== {13'h0100, 8'h55}) begin errors++; $display("FAIL pat_first_lo: got %0h expected %0h", w[0], {13'h0100, 8'h55}); end
    checks++;
    if (w[1] !== {13'h0101, 8'h33}) begin errors++; $display("FAIL pat_first_hi: got %0h expected %0h", w[1], {13'h0101, 8'h33}); end
    checks++;
    if (w[2] !== {13'h0212, 8'h55}) begin errors++; $display("FAIL pat_x8y9_lo: got %0h expected %0h", w[2], {13'h0212, 8'h55}); end
    checks++;
    if (w[3] !== {13'h0213, 8'h33}) begin errors++; $display("FAIL pat_x8y9_hi: got %0h expected %0h", w[3], {13'h0213, 8'h33}); end
    post = 0; fin = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clock);
      if (bus.Frm_We) post++;
      if (Sig_CamCaptureFinish) fin++;
    end
    checks++;
    if (post > 2 || post % 2 != 0) begin errors++; $display("FAIL abort_writes: got %0d expected 0 or 2", post); end
    checks++;
    if (fin != 0) begin errors++; $display("FAIL abort_finish: got %0d expected 0", fin); end
    checks++;
    if ({bus.Pix_Ready, bus.Dth_Addr} !== 11'd0) begin errors++; $display("FAIL abort_idle: got %0h expected 0", {bus.Pix_Ready, bus.Dth_Addr}); end
    Cam_Capture = 1'b1;
    wait_load(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_restart: got none expected Dth_Addr 200"); end
    Cam_Capture = 1'b0;
    pix_mode = 1'b0; gap_en = 1'b0;
    repeat (10) @(negedge sys_clock);
  endtask
  task automatic test_reset_mid;
    bit ok, seen;
    int bad;
    fill_flat(8'h80);
    {Reg_A002, Reg_A003} = 16'h0100;
    valid_en = 1'b1;
    Cam_Capture = 1'b1;
    wait_load(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rm_load_start: got none expected Dth_Addr 200"); end
    repeat (60) @(negedge sys_clock);
    @(posedge sys_clock);
    #2 sys_resetn = 1'b0;
    Cam_Capture = 1'b0;
    #1;
    checks++;
    if (outs() !== 35'd0) begin errors++; $display("FAIL rm_expose_reset: got %0h expected 0", outs()); end
    @(negedge sys_clock);
    sys_resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clock);
      if (outs() !== 35'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rm_stay_idle: got %0d active cycles expected 0", bad); end
    {Reg_A002, Reg_A003} = 16'h0000;
    Cam_Capture = 1'b1;
    wait_load(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rm_reload: got none expected Dth_Addr 200"); end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge sys_clock);
      if (bus.Frm_We) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rm_stream_write: got none expected Frm_We"); end
    #1 sys_resetn = 1'b0;
    #1;
    checks++;
    if (outs() !== 35'd0) begin errors++; $display("FAIL rm_stream_reset: got %0h expected 0", outs()); end
    Cam_Capture = 1'b0;
    repeat (3) @(negedge sys_clock);
    sys_resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clock);
      if (bus.Frm_We || Sig_CamCaptureFinish) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rm_no_writes: got %0d expected 0", bad); end
  endtask
  initial begin
    test_reset;
    test_full_frame;
    test_exposure;
    test_pattern_abort;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
